// File: rtl/sram_ws.sv
// Single-port word SRAM with byte-lane writes and a fixed number of wait states.
// Each transaction is captured on select, optionally held in WAIT, then completed from ACK.
module sram_ws #(
  parameter int unsigned          DATAWIDTH   = 32,
  parameter int unsigned          ADDRWIDTH   = 13,
  parameter int unsigned          DEPTH       = 2048,
  parameter int unsigned          WAIT_STATES = 0,
  parameter logic [DATAWIDTH-1:0] INIT_VALUE  = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   select,
  input  logic [DATAWIDTH/8-1:0] wstrb,
  input  logic [ADDRWIDTH-1:0]   addr,
  input  logic [DATAWIDTH-1:0]   data_i,
  output logic                   ready,
  output logic [DATAWIDTH-1:0]   data_o,
  output logic                   err
);

  localparam int unsigned NumBytes = DATAWIDTH / 8;
  localparam int unsigned Lsb      = $clog2(NumBytes);
  localparam int unsigned IdxW     = ADDRWIDTH - Lsb;
  localparam int unsigned MemAw    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] ACK  = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [NumBytes-1:0]  wstrb_q;
  logic [IdxW-1:0]      idx_q;
  logic [DATAWIDTH-1:0] data_q;
  logic                 ready_q;
  logic                 err_q;
  logic [DATAWIDTH-1:0] data_o_q;
  logic                 oor;
  logic [MemAw-1:0]     mem_idx;

  // Contents come up at INIT_VALUE and are never touched by reset.
  logic [DATAWIDTH-1:0] mem [DEPTH] = '{default: INIT_VALUE};

  if (Lsb > 0) begin : g_unused_lsb
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^addr[Lsb-1:0];
  end

  assign oor     = (32'(idx_q) >= DEPTH);
  assign mem_idx = idx_q[MemAw-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (select) begin
          if (WAIT_STATES > 0) begin
            state_d = WAIT;
            cnt_d   = 4'(WAIT_STATES - 1);
          end else begin
            state_d = ACK;
          end
        end
      end
      WAIT: begin
        if (!select) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ACK is the access cycle: memory and the registered outputs update on its closing edge,
  // so ready is seen one cycle later and lasts exactly one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      wstrb_q  <= '0;
      idx_q    <= '0;
      data_q   <= '0;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
      data_o_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      if (state_q == IDLE && select) begin
        wstrb_q <= wstrb;
        idx_q   <= addr[ADDRWIDTH-1:Lsb];
        data_q  <= data_i;
      end
      if (state_q == ACK) begin
        ready_q <= 1'b1;
        err_q   <= oor;
        if (wstrb_q == '0) begin
          data_o_q <= oor ? '0 : mem[mem_idx];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && state_q == ACK && !oor) begin
      for (int k = 0; k < NumBytes; k++) begin
        if (wstrb_q[k]) mem[mem_idx][8*k +: 8] <= data_q[8*k +: 8];
      end
    end
  end

  assign ready  = ready_q;
  assign err    = err_q;
  assign data_o = data_o_q;

endmodule
